// File: rtl/plate_scheduler_if.sv
// plate_scheduler_if: spawn handshake plus the plate sprite engine bus.
//
// Handshake rules: a spawn transfers on every rising clk edge where
// spawn_valid and spawn_ready are both high; spawn_x/spawn_y must be stable
// while spawn_valid is high, and spawn_ready is independent of spawn_valid.
// The sprite bus is a request/complete pair: spr_start pulses one cycle with
// spr_x/spr_y/spr_slot valid, which stay put until the engine pulses spr_done.
interface plate_scheduler_if #(
   parameter int SLOTS = 8,
   parameter int CORDW = 16
);
   localparam int SW = $clog2(SLOTS);

   logic                    spawn_valid;
   logic                    spawn_ready;
   logic [19:0]             spawn_x;
   logic [19:0]             spawn_y;
   logic                    spr_start;
   logic signed [CORDW-1:0] spr_x;
   logic signed [CORDW-1:0] spr_y;
   logic [SW-1:0]           spr_slot;
   logic                    spr_done;

   // scheduler side
   modport master (
      input  spawn_valid, spawn_x, spawn_y, spr_done,
      output spawn_ready, spr_start, spr_x, spr_y, spr_slot
   );

   // spawner / sprite engine side
   modport slave (
      output spawn_valid, spawn_x, spawn_y, spr_done,
      input  spawn_ready, spr_start, spr_x, spr_y, spr_slot
   );
endinterface

// File: rtl/plate_scheduler.sv
// plate_scheduler: keeps a table of SLOTS world-space plates, retires the ones
// scrolled off the bottom at frame start, and per scanline grants the single
// plate sprite engine to the lowest-index plate whose top row is that line.
// Optional macro PLATE_SCHED_STATS_EN adds drop_cnt: matches lost while the
// engine was busy drawing.
module plate_scheduler #(
   parameter int SLOTS         = 8,
   parameter int CORDW         = 16,
   parameter int PLATE_W       = 64,
   parameter int PLATE_H       = 16,
   parameter int SCREEN_BOTTOM = 469,
   localparam int SW           = $clog2(SLOTS)
) (
   input  logic                    clk,
   input  logic                    i_rst_n,
   input  logic                    frame,
   input  logic                    line,
   input  logic signed [CORDW-1:0] sy,
   input  logic [19:0]             screen_height,
   plate_scheduler_if.master       bus,
   output logic                    busy,
   output logic [SLOTS-1:0]        active_mask,
   output logic [1:0]              fsm_state
`ifdef PLATE_SCHED_STATS_EN
   ,
   output logic [15:0]             drop_cnt
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
   localparam logic [1:0] DRAW  = 2'd3;

   // top screen row of a plate sitting exactly at the scroll height
   localparam logic signed [20:0] TOP_OFS    = 21'(SCREEN_BOTTOM - PLATE_H);
   localparam logic signed [20:0] RETIRE_LIM = 21'(-PLATE_H);

   // PLATE_W is carried only for collision users downstream
   if (PLATE_W > 0) begin : g_plate_w_present
   end

   logic [SLOTS-1:0]        valid;
   logic [SLOTS-1:0]        valid_nxt;
   logic [19:0]             slot_x [SLOTS];
   logic [19:0]             slot_y [SLOTS];
   logic signed [CORDW-1:0] scr_y  [SLOTS];
   logic [SLOTS-1:0]        retire;
   logic                    free_found;
   logic [SW-1:0]           free_idx;

   logic [1:0]              state;
   logic [SW-1:0]           idx;
   logic signed [CORDW-1:0] sy_l;
   logic signed [CORDW-1:0] spr_x_q;
   logic signed [CORDW-1:0] spr_y_q;
   logic [SW-1:0]           spr_slot_q;
   logic [20:0]             x21;

   // per-slot screen row and off-bottom test, all slots in parallel
   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      logic signed [20:0] rel;
      logic signed [20:0] scr21;
      assign rel       = $signed({1'b0, slot_y[i]}) - $signed({1'b0, screen_height});
      assign scr21     = TOP_OFS - rel;
      assign scr_y[i]  = scr21[CORDW-1:0];
      assign retire[i] = valid[i] && (rel < RETIRE_LIM);
   end

   // lowest-index free slot, searched on the pre-retire table
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_found = 1'b1;
            free_idx   = SW'(i);
         end
      end
   end

   // next valid vector: frame retirement, then the accepted spawn
   always_comb begin
      valid_nxt = valid;
      if (frame) valid_nxt = valid_nxt & ~retire;
      if (bus.spawn_valid && free_found) valid_nxt[free_idx] = 1'b1;
   end

   // slot valid bits
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) valid <= '0;
      else          valid <= valid_nxt;
   end

   // slot payload; meaningless while the slot is invalid, so no reset
   always_ff @(posedge clk) begin
      if (bus.spawn_valid && free_found) begin
         slot_x[free_idx] <= bus.spawn_x;
         slot_y[free_idx] <= bus.spawn_y;
      end
   end

   assign x21 = {1'b0, slot_x[idx]};

   // grant FSM: IDLE -> SCAN (one slot per cycle) -> ISSUE -> DRAW
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         sy_l       <= '0;
         spr_x_q    <= '0;
         spr_y_q    <= '0;
         spr_slot_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (line) begin
                  sy_l  <= sy;
                  idx   <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (valid[idx] && (scr_y[idx] == sy_l)) begin
                  spr_x_q    <= x21[CORDW-1:0];
                  spr_y_q    <= scr_y[idx];
                  spr_slot_q <= idx;
                  state      <= ISSUE;
               end else if (idx == SW'(SLOTS - 1)) begin
                  state <= IDLE;
               end else begin
                  idx <= idx + SW'(1);
               end
            end
            ISSUE:   state <= DRAW;
            DRAW:    if (bus.spr_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.spr_start   = (state == ISSUE);
   assign bus.spr_x       = spr_x_q;
   assign bus.spr_y       = spr_y_q;
   assign bus.spr_slot    = spr_slot_q;
   assign bus.spawn_ready = free_found;
   assign busy            = (state != IDLE);
   assign active_mask     = valid;
   assign fsm_state       = state;

`ifdef PLATE_SCHED_STATS_EN
   localparam int HW = $clog2(SLOTS + 1);

   logic [HW-1:0] hit_cnt;
   logic [16:0]   drop_sum;

   // number of valid plates whose top row is the current line
   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (valid[i] && (scr_y[i] == sy)) hit_cnt = hit_cnt + HW'(1);
      end
   end

   assign drop_sum = {1'b0, drop_cnt} + 17'(hit_cnt);

   // saturating count of matches lost to a busy engine, cleared per frame
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)                      drop_cnt <= '0;
      else if (frame)                    drop_cnt <= '0;
      else if (line && (state == DRAW))  drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_plate_scheduler.sv
// tb_plate_scheduler: directed vectors for plate_scheduler (SLOTS=8, CORDW=16).
// With screen_height=0 a plate at world y has its top row at 453 - y.
module tb_plate_scheduler;

   localparam int SLOTS = 8;
   localparam int CORDW = 16;
   localparam int W     = 3 + 2 * CORDW;

   typedef struct {
      logic signed [15:0] sy;
      bit                 hit;
      logic [2:0]         slot;
      logic signed [15:0] x;
      logic signed [15:0] y;
   } vec_t;

   logic               clk;
   logic               i_rst_n;
   logic               frame;
   logic               line;
   logic signed [15:0] sy;
   logic [19:0]        screen_height;
   logic               busy;
   logic [7:0]         active_mask;
   logic [1:0]         fsm_state;
`ifdef PLATE_SCHED_STATS_EN
   logic [15:0]        drop_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];
   vec_t vecs[10];
   logic [19:0] fx[9];
   logic [19:0] fy[9];

   plate_scheduler_if #(.SLOTS(SLOTS), .CORDW(CORDW)) bus ();

   plate_scheduler dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .frame         (frame),
      .line          (line),
      .sy            (sy),
      .screen_height (screen_height),
      .bus           (bus),
      .busy          (busy),
      .active_mask   (active_mask),
      .fsm_state     (fsm_state)
`ifdef PLATE_SCHED_STATS_EN
      ,
      .drop_cnt      (drop_cnt)
`endif
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] pack(input logic [2:0] s, input logic signed [15:0] x,
                                         input logic signed [15:0] y);
      return {s, x, y};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1;
   endtask

   task automatic do_spawn(input logic [19:0] x, input logic [19:0] y);
      @(negedge clk);
      bus.spawn_valid = 1'b1;
      bus.spawn_x     = x;
      bus.spawn_y     = y;
      @(negedge clk);
      bus.spawn_valid = 1'b0;
   endtask

   task automatic pulse_frame(input logic [19:0] sh);
      @(negedge clk);
      frame         = 1'b1;
      screen_height = sh;
      @(negedge clk);
      frame = 1'b0;
   endtask

   // line pulse, then watch SLOTS+2 cycles for starts; scoreboard checks grant
   task automatic run_line(input string name, input logic signed [15:0] lsy,
                           input bit hit, input logic [W-1:0] exp);
      int starts;
      bit matched;
      starts  = 0;
      matched = 0;
      if (hit) exp_q.push_back(exp);
      @(negedge clk);
      sy   = lsy;
      line = 1'b1;
      for (int c = 0; c < SLOTS + 2; c++) begin
         @(negedge clk);
         line = 1'b0;
         if (bus.spr_start) begin
            starts++;
            if (exp_q.size() != 0) begin
               check({name, "_grant"}, 64'(pack(bus.spr_slot, bus.spr_x, bus.spr_y)),
                     64'(exp_q.pop_front()));
               matched = 1'b1;
            end
         end
      end
      if (hit && !matched) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_grant: got no spr_start in %0d cycles, expected one", name, SLOTS + 2);
         exp_q.delete();
      end
      check({name, "_pulses"}, 64'(starts), hit ? 64'd1 : 64'd0);
   endtask

   task automatic finish_draw(input string name);
      @(negedge clk);
      bus.spr_done = 1'b1;
      @(negedge clk);
      bus.spr_done = 1'b0;
      check({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      // stimulus tables
      for (int k = 0; k < 9; k++) fx[k] = 20'(5 + 10 * k);
      fy[0] = 300; fy[1] = 333; fy[2] = 353; fy[3] = 250; fy[4] = 400;
      fy[5] = 353; fy[6] = 290; fy[7] = 440; fy[8] = 123;
      vecs[0] = '{16'sd153, 1'b1, 3'd0, 16'sd5,  16'sd153};
      vecs[1] = '{16'sd120, 1'b1, 3'd1, 16'sd15, 16'sd120};
      vecs[2] = '{16'sd100, 1'b1, 3'd2, 16'sd25, 16'sd100};
      vecs[3] = '{16'sd13,  1'b1, 3'd7, 16'sd75, 16'sd13};
      vecs[4] = '{16'sd163, 1'b1, 3'd6, 16'sd65, 16'sd163};
      vecs[5] = '{16'sd50,  1'b0, 3'd0, 16'sd0,  16'sd0};
      vecs[6] = '{16'sd203, 1'b1, 3'd3, 16'sd35, 16'sd203};
      vecs[7] = '{16'sd53,  1'b1, 3'd4, 16'sd45, 16'sd53};
      vecs[8] = '{16'sd0,   1'b0, 3'd0, 16'sd0,  16'sd0};
      vecs[9] = '{16'sd101, 1'b0, 3'd0, 16'sd0,  16'sd0};

      i_rst_n         = 1'b0;
      frame           = 1'b0;
      line            = 1'b0;
      sy              = '0;
      screen_height   = '0;
      bus.spawn_valid = 1'b0;
      bus.spawn_x     = '0;
      bus.spawn_y     = '0;
      bus.spr_done    = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_start", 64'(bus.spr_start), 64'd0);
      check("rst_x", 64'(bus.spr_x), 64'd0);
      check("rst_y", 64'(bus.spr_y), 64'd0);
      check("rst_slot", 64'(bus.spr_slot), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mask", 64'(active_mask), 64'd0);
      check("rst_ready", 64'(bus.spawn_ready), 64'd1);
      check("rst_state", 64'(fsm_state), 64'd0);
      i_rst_n = 1'b1;

      // single plate: y=200 at height 0 -> top row 253
      do_spawn(20'd100, 20'd200);
      check("spawn1_mask", 64'(active_mask), 64'h01);
      run_line("single", 16'sd253, 1'b1, pack(3'd0, 16'sd100, 16'sd253));
      finish_draw("single");

      // fill all slots with spawn_valid held high; 9th request refused
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         logic [8:0] m;
         m = (9'd1 << k) - 9'd1;
         @(negedge clk);
         check("fill_mask", 64'(active_mask), 64'(m[7:0]));
         check("fill_ready", 64'(bus.spawn_ready), (k < 8) ? 64'd1 : 64'd0);
         bus.spawn_valid = 1'b1;
         bus.spawn_x     = fx[k];
         bus.spawn_y     = fy[k];
      end
      @(negedge clk);
      bus.spawn_valid = 1'b0;
      check("full_mask", 64'(active_mask), 64'hFF);
      check("full_ready", 64'(bus.spawn_ready), 64'd0);

      // table-driven lookups with all eight plates resident
      foreach (vecs[i]) begin
         run_line("vec", vecs[i].sy, vecs[i].hit, pack(vecs[i].slot, vecs[i].x, vecs[i].y));
         if (vecs[i].hit) finish_draw("vec");
      end

      // engine held in DRAW: lines ignored, outputs stable
      pulse_frame(20'd0);
`ifdef PLATE_SCHED_STATS_EN
      check("drop_clr0", 64'(drop_cnt), 64'd0);
`endif
      run_line("hold", 16'sd100, 1'b1, pack(3'd2, 16'sd25, 16'sd100));
      for (int l = 1; l <= 16; l++) run_line("hold_line", 16'(100 + l), 1'b0, '0);
      check("hold_state", 64'(fsm_state), 64'd3);
      check("hold_x", 64'(bus.spr_x), 64'd25);
      check("hold_y", 64'(bus.spr_y), 64'd100);
`ifdef PLATE_SCHED_STATS_EN
      check("drop_hold", 64'(drop_cnt), 64'd0);
`endif
      run_line("drop", 16'sd120, 1'b0, '0);
`ifdef PLATE_SCHED_STATS_EN
      check("drop_one", 64'(drop_cnt), 64'd1);
`endif
      finish_draw("hold");

      // spr_done outside DRAW is ignored
      @(negedge clk);
      bus.spr_done = 1'b1;
      @(negedge clk);
      bus.spr_done = 1'b0;
      check("stray_done", 64'(fsm_state), 64'd0);
      pulse_frame(20'd0);
`ifdef PLATE_SCHED_STATS_EN
      check("drop_clr1", 64'(drop_cnt), 64'd0);
`endif
      check("frame0_mask", 64'(active_mask), 64'hFF);

      // retire at height 300: only slot3 (y=250) is below -PLATE_H
      pulse_frame(20'd300);
      check("retire_mask", 64'(active_mask), 64'hF7);
      check("retire_ready", 64'(bus.spawn_ready), 64'd1);
      run_line("scroll", 16'sd453, 1'b1, pack(3'd0, 16'sd5, 16'sd453));
      finish_draw("scroll");

      // refill slot3, then spawn and retire in the same cycle
      do_spawn(20'd200, 20'd1000);
      check("refill_mask", 64'(active_mask), 64'hFF);
      @(negedge clk);
      bus.spawn_valid = 1'b1;
      bus.spawn_x     = 20'd222;
      bus.spawn_y     = 20'd500;
      frame           = 1'b1;
      screen_height   = 20'd318;
      @(negedge clk);
      frame = 1'b0;
      check("same_mask", 64'(active_mask), 64'hBE);
      check("same_ready", 64'(bus.spawn_ready), 64'd1);
      @(negedge clk);
      bus.spawn_valid = 1'b0;
      check("next_mask", 64'(active_mask), 64'hBF);
      run_line("reuse", 16'sd271, 1'b1, pack(3'd0, 16'sd222, 16'sd271));

      // reset while in DRAW
      @(negedge clk);
      i_rst_n = 1'b0;
      #1;
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_start", 64'(bus.spr_start), 64'd0);
      check("mid_xy", 64'({bus.spr_x, bus.spr_y}), 64'd0);
      check("mid_slot", 64'(bus.spr_slot), 64'd0);
      check("mid_mask", 64'(active_mask), 64'd0);
      check("mid_ready", 64'(bus.spawn_ready), 64'd1);
      @(negedge clk);
      i_rst_n = 1'b1;
      run_line("post_rst", 16'sd271, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
